// File: rtl/noc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// noc_pkg : shared types and helpers for the crossbar switch allocator
// rev 1.0
// ----------------------------------------------------------------------------
package noc_pkg;

  // Widest port index supported; blocks narrow this to their own $clog2(PORTS).
  localparam int unsigned NOC_IDX_W_MAX = 8;

  typedef logic [NOC_IDX_W_MAX-1:0] port_idx_t;

  typedef enum logic {
    ALLOC_IDLE   = 1'b0,
    ALLOC_LOCKED = 1'b1
  } alloc_state_e;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned ports);
    return (idx + 32'd1 >= ports) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_pick : combinational round-robin picker, first request at or above ptr
// rev 1.0
// ----------------------------------------------------------------------------
module rr_pick #(
  parameter  int PORTS = 2,
  localparam int IDX_W = $clog2(PORTS)
) (
  input  logic [PORTS-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] winner_o,
  output logic             found_o
);

  logic [IDX_W-1:0] idx;

  // Scan offsets from the far end down so the nearest request to ptr wins last.
  always_comb begin
    idx      = ptr_i;
    winner_o = ptr_i;
    found_o  = 1'b0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(ptr_i) + k) % PORTS);
      if (req_i[idx]) begin
        winner_o = idx;
        found_o  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/crossbar_alloc_rr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// crossbar_alloc_rr : per-output round-robin wormhole switch allocator
// rev 1.0
// ----------------------------------------------------------------------------
module crossbar_alloc_rr
  import noc_pkg::*;
#(
  parameter  int PORTS = 2,
  localparam int IDX_W = $clog2(PORTS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PORTS-1:0]       req_i,
  input  logic [PORTS*IDX_W-1:0] dest_i,
  input  logic [PORTS-1:0]       tail_i,
  input  logic [PORTS-1:0]       out_ready_i,
  output logic [PORTS-1:0]       gnt_o,
  output logic [PORTS*IDX_W-1:0] sel_o,
  output logic [PORTS-1:0]       sel_valid_o,
  output logic [PORTS-1:0]       busy_o
);

  alloc_state_e     state_q [PORTS];
  alloc_state_e     state_d [PORTS];
  logic [IDX_W-1:0] owner_q [PORTS];
  logic [IDX_W-1:0] owner_d [PORTS];
  logic [IDX_W-1:0] ptr_q   [PORTS];
  logic [IDX_W-1:0] ptr_d   [PORTS];

  logic [PORTS-1:0] locked_in;
  logic [PORTS-1:0] cand    [PORTS];
  logic [IDX_W-1:0] win     [PORTS];
  logic [PORTS-1:0] found;
  logic [PORTS-1:0] ogrant  [PORTS];
  logic [IDX_W-1:0] sel     [PORTS];
  logic [PORTS-1:0] xfer;
  logic [PORTS-1:0] busy;

  always_comb begin
    locked_in = '0;
    for (int o = 0; o < PORTS; o++) begin
      if (state_q[o] == ALLOC_LOCKED) locked_in[owner_q[o]] = 1'b1;
    end
  end

  // Inputs already holding an output are kept out of every idle arbitration.
  always_comb begin
    for (int o = 0; o < PORTS; o++) begin
      for (int i = 0; i < PORTS; i++) begin
        cand[o][i] = req_i[i] && (dest_i[i*IDX_W +: IDX_W] == IDX_W'(o)) && !locked_in[i];
      end
    end
  end

  generate
    for (genvar o = 0; o < PORTS; o++) begin : g_pick
      rr_pick #(.PORTS(PORTS)) u_pick (
        .req_i    (cand[o]),
        .ptr_i    (ptr_q[o]),
        .winner_o (win[o]),
        .found_o  (found[o])
      );
    end
  endgenerate

  always_comb begin
    for (int o = 0; o < PORTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      ogrant[o]  = '0;
      sel[o]     = ptr_q[o];
      xfer[o]    = 1'b0;
      busy[o]    = 1'b0;
    end
    for (int o = 0; o < PORTS; o++) begin
      case (state_q[o])
        ALLOC_IDLE: begin
          if (found[o]) sel[o] = win[o];
          if (found[o] && out_ready_i[o]) begin
            xfer[o]           = 1'b1;
            ogrant[o][win[o]] = 1'b1;
            if (tail_i[win[o]]) begin
              ptr_d[o] = IDX_W'(rr_next(32'(win[o]), PORTS));
            end else begin
              state_d[o] = ALLOC_LOCKED;
              owner_d[o] = win[o];
            end
          end
        end
        ALLOC_LOCKED: begin
          sel[o]  = owner_q[o];
          busy[o] = 1'b1;
          // A low owner request is a bubble; the lock is held regardless.
          if (req_i[owner_q[o]] && out_ready_i[o]) begin
            xfer[o]               = 1'b1;
            ogrant[o][owner_q[o]] = 1'b1;
            if (tail_i[owner_q[o]]) begin
              state_d[o] = ALLOC_IDLE;
              ptr_d[o]   = IDX_W'(rr_next(32'(owner_q[o]), PORTS));
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < PORTS; o++) begin
        state_q[o] <= ALLOC_IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < PORTS; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
    end
  end

  // Outputs are forced low for the whole time reset is held, not just after an edge.
  always_comb begin
    gnt_o       = '0;
    sel_o       = '0;
    sel_valid_o = '0;
    busy_o      = '0;
    if (rst_n) begin
      for (int o = 0; o < PORTS; o++) begin
        gnt_o                     = gnt_o | ogrant[o];
        sel_o[o*IDX_W +: IDX_W]   = sel[o];
        sel_valid_o[o]            = xfer[o];
        busy_o[o]                 = busy[o];
      end
    end
  end

  generate
    for (genvar i = 0; i < PORTS; i++) begin : g_in_chk
      logic [PORTS-1:0] gnt_col;
      always_comb begin
        for (int o = 0; o < PORTS; o++) gnt_col[o] = ogrant[o][i];
      end
      a_one_gnt: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(gnt_col));
      a_dest_rng: assert property (@(posedge clk) disable iff (!rst_n)
        (req_i[i] && !locked_in[i]) |-> (int'(dest_i[i*IDX_W +: IDX_W]) < PORTS));
    end
    for (genvar o = 0; o < PORTS; o++) begin : g_out_chk
      a_sel_req: assert property (@(posedge clk) disable iff (!rst_n)
        sel_valid_o[o] |-> req_i[sel[o]]);
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/crossbar_alloc_rr.md
Name: crossbar_alloc_rr

Overview:
Per-output round-robin switch allocator that sequences the PORTS-way crossbar. Packets are multi-flit. The allocator arbitrates among inputs requesting the same output and locks that output to the winner until the tail flit transfers (wormhole). It drives the crossbar per-output mux selects and per-input grants, gated by downstream readiness.

Parameters:
PORTS, 2, number of crossbar input ports and output ports (>=2; non-power-of-2 legal)
IDX_W, $clog2(PORTS), localparam, width of port indices

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active-low
req_i[PORTS]  in  1  input i presents a valid flit this cycle
dest_i[PORTS]  in  IDX_W  requested output port; meaningful only on a head flit (input not locked)
tail_i[PORTS]  in  1  flit on input i is the last of its packet (single-flit packet = head+tail)
out_ready_i[PORTS]  in  1  output o can accept a flit this cycle (inverse of crossbar backpressure)
gnt_o[PORTS]  out  1  flit on input i transfers this cycle
sel_o[PORTS]  out  IDX_W  input index routed to output o
sel_valid_o[PORTS]  out  1  output o carries a transferring flit this cycle
busy_o[PORTS]  out  1  output o is locked to a packet in progress

Behaviour:
- Reset (rst_n low, async): every output goes to IDLE, owner 0, round-robin pointer 0. All outputs are 0 while reset is asserted. Reset mid-packet drops every lock, with no completion.
- Per-output state: IDLE or LOCKED, plus owner_q[IDX_W] and ptr_q[IDX_W]. All updates occur on the rising clk edge.
- Input masking: an input already owning some LOCKED output is excluded from every IDLE arbitration. Each input is granted by at most one output per cycle.
- IDLE, output o:
  - Candidates are inputs i with req_i[i] && dest_i[i]==o && !locked_in[i].
  - Winner is the first candidate found scanning cyclically from ptr_q upward, wrapping PORTS-1 to 0.
  - Arbitration and grant are combinational, so head-flit latency is 0 cycles.
  - If a winner exists and out_ready_i[o]=1: sel_o=winner, sel_valid_o=1, gnt_o[winner]=1.
  - Winner with tail: stay IDLE and set ptr_q = (winner+1) mod PORTS.
  - Winner without tail: go to LOCKED with owner_q=winner; ptr_q is unchanged.
  - If out_ready_i[o]=0: no transfer and no state or pointer change. Arbitration re-runs next cycle and may pick a different winner.
  - No candidate: sel_o=ptr_q (don't-care), sel_valid_o=0.
- LOCKED, output o:
  - sel_o=owner_q and busy_o[o]=1. dest_i[owner_q] is ignored. Other inputs naming o are not granted.
  - Transfer occurs when req_i[owner_q] && out_ready_i[o]; then gnt_o[owner_q]=1 and sel_valid_o[o]=1.
  - Owner req low produces a bubble; the lock is held.
  - Tail transfer: go to IDLE and set ptr_q = (owner_q+1) mod PORTS. A new head can win the output in the very next cycle.
- gnt_o[i] is the OR over outputs of the per-output grant to i. Asserting more than one per input is illegal (assertion).
- Simultaneous events:
  - Tail on output A and a head from the same input to output B in the same cycle are impossible, because there is one flit per input per cycle.
  - A head arriving in the tail cycle of another packet to the same output waits one cycle.
- Fairness: with N persistent requesters on one output, each wins once every N packets.
- Assertions:
  - dest_i < PORTS whenever req_i is high on a head flit.
  - sel_valid_o implies the selected input's req_i is high.

Decomposition:
- Package noc_pkg:
  - typedef port_idx_t (logic [IDX_W-1:0])
  - enum alloc_state_e {ALLOC_IDLE, ALLOC_LOCKED}
  - function rr_next(idx, PORTS) giving wrap-around increment
- One sub-module, rr_pick: PORTS-wide request vector plus pointer in, winner index and found flag out, purely combinational. Instantiated once per output.
- The top level holds the per-output FSMs, the input lock mask and the grant OR-reduction.

Test Plan:
- Reset then idle: rst_n low mid-cycle gives all outputs 0 immediately; release with no req gives gnt_o=0, sel_valid_o=0, busy_o=0.
- Contention, PORTS=2: inputs 0 and 1 both send 1-flit packets to output 1 every cycle with ready high. Grants alternate 0,1,0,1 and sel_o[1] alternates to match.
- Wormhole lock: input 0 sends a 3-flit packet to output 1 while input 1 requests output 1. busy_o[1] is high for cycles 1-2, and input 1 is granted in cycle 3 (after the tail).
- Backpressure: out_ready_i[1]=0 for 2 cycles mid-packet. No gnt and no lock change; the flit transfers on the cycle ready returns, and the tail then releases the lock.
- Parallel paths, PORTS=3: input 0 to output 2 and input 2 to output 0 in the same cycle both grant. Pointer wrap: ptr at 2 with all three inputs contending wins input 2, then 0, then 1.
- Reset mid-packet: rst_n pulsed while output 1 is LOCKED. busy_o[1]=0 and ptr=0, and a new head from input 1 wins immediately after release.
